// File: rtl/huff_bit_packer.sv
// rtl/huff_bit_packer.sv - packs MSB-first variable-length codewords into OUT_WIDTH words
// Optional stream bit counter output enabled by HUFF_BIT_PACKER_CNT_EN.
module huff_bit_packer #(
  parameter int   IN_WIDTH  = 32,
  parameter int   LEN_WIDTH = 6,
  parameter int   OUT_WIDTH = 64,
  parameter logic PAD_BIT   = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [IN_WIDTH-1:0]            in_data,
  input  logic [LEN_WIDTH-1:0]           in_len,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_WIDTH-1:0]           out_data,
  output logic [$clog2(OUT_WIDTH+1)-1:0] out_bits,
`ifdef HUFF_BIT_PACKER_CNT_EN
  output logic                           out_last,
  output logic [31:0]                    stream_bits
`else
  output logic                           out_last
`endif
);

  localparam int ACC_W  = OUT_WIDTH + IN_WIDTH;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam int BITS_W = $clog2(OUT_WIDTH + 1);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_WIDTH);
  localparam logic [FILL_W-1:0] ACC_W_F = FILL_W'(ACC_W);

  logic [1:0]           state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [BITS_W-1:0]    out_bits_q, out_bits_d;
  logic                 out_last_q, out_last_d;

  logic                 accept, out_free, emit, final_word, last_hs;
  logic [FILL_W-1:0]    len_c, shamt;
  logic [ACC_W-1:0]     cw_masked;
  logic [OUT_WIDTH-1:0] top_word, pad_mask;

  assign in_ready   = rst_n && (state_q == ST_RUN) && (fill_q < OUT_W_F);
  assign accept     = in_valid && in_ready;
  assign out_free   = !out_valid_q || out_ready;
  assign emit       = out_free && (((state_q == ST_RUN) && (fill_q >= OUT_W_F)) || (state_q == ST_FLUSH));
  assign final_word = (state_q == ST_FLUSH) && (fill_q <= OUT_W_F);
  assign last_hs    = out_valid_q && out_ready && out_last_q;

  assign len_c     = (int'(in_len) > IN_WIDTH) ? FILL_W'(IN_WIDTH) : FILL_W'(in_len);
  assign cw_masked = ACC_W'(in_data) & ~({ACC_W{1'b1}} << len_c);
  // Codeword lands directly below the current fill, keeping the accumulator MSB-aligned.
  assign shamt     = ACC_W_F - fill_q - len_c;
  assign top_word  = acc_q[ACC_W-1 -: OUT_WIDTH];
  assign pad_mask  = PAD_BIT ? ({OUT_WIDTH{1'b1}} >> fill_q) : '0;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    fill_d      = fill_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_bits_d  = out_bits_q;
    out_last_d  = out_last_q;

    if (accept) begin
      acc_d  = acc_q | (cw_masked << shamt);
      fill_d = fill_q + len_c;
      if (in_last) state_d = ST_FLUSH;
    end

    if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = final_word ? (top_word | pad_mask) : top_word;
      out_bits_d  = final_word ? BITS_W'(fill_q) : BITS_W'(OUT_WIDTH);
      out_last_d  = final_word;
      acc_d       = acc_q << OUT_WIDTH;
      fill_d      = final_word ? '0 : fill_q - OUT_W_F;
      if (final_word) state_d = ST_WAIT;
    end else if (out_free) begin
      out_valid_d = 1'b0;
    end

    if ((state_q == ST_WAIT) && last_hs) begin
      acc_d   = '0;
      fill_d  = '0;
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      acc_q       <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_bits_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_bits_q  <= out_bits_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_bits  = out_bits_q;
  assign out_last  = out_last_q;

`ifdef HUFF_BIT_PACKER_CNT_EN
  logic [31:0] stream_bits_q;
  logic [32:0] stream_sum;

  assign stream_sum = {1'b0, stream_bits_q} + 33'(len_c);

  always_ff @(posedge clk) begin
    if (!rst_n || last_hs) begin
      stream_bits_q <= '0;
    end else if (accept) begin
      stream_bits_q <= stream_sum[32] ? 32'hFFFF_FFFF : stream_sum[31:0];
    end
  end

  assign stream_bits = stream_bits_q;
`endif

endmodule

// File: tb/tb_huff_bit_packer.sv
// tb/tb_huff_bit_packer.sv - self-checking bench for huff_bit_packer (OUT=16, IN=8, PAD=1)
module tb_huff_bit_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [5:0]  in_len;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [4:0]  out_bits;
  logic        out_last;
`ifdef HUFF_BIT_PACKER_CNT_EN
  logic [31:0] stream_bits;
`endif

  always #5 clk = ~clk;

  huff_bit_packer #(
    .IN_WIDTH(8), .LEN_WIDTH(6), .OUT_WIDTH(16), .PAD_BIT(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_len(in_len), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_bits(out_bits), .out_last(out_last)
`ifdef HUFF_BIT_PACKER_CNT_EN
    , .stream_bits(stream_bits)
`endif
  );

  typedef struct {
    logic [15:0] d;
    logic [4:0]  b;
    logic        l;
  } word_t;

  typedef struct {
    logic [7:0]  d;
    logic [5:0]  len;
    logic        lst;
    int          n;
    logic [15:0] wd0;
    logic [4:0]  wb0;
    logic        wl0;
    logic [15:0] wd1;
    logic [4:0]  wb1;
    logic        wl1;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  word_t got[$];
  word_t exp_q[$];
  bit    mq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: records handshakes and checks that a stalled word is held stable.
  logic  stall_q = 1'b0;
  word_t held;
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got.push_back('{d: out_data, b: out_bits, l: out_last});
    if (rst_n && stall_q && out_valid)
      chk("hold_word", {out_data, out_bits, out_last}, {held.d, held.b, held.l});
    stall_q = rst_n && out_valid && !out_ready;
    held    = '{d: out_data, b: out_bits, l: out_last};
  end

  // Reference model: a plain bit queue, cut into 16-bit words by the stream rules.
  function automatic word_t pop_word(int n, logic lst);
    word_t w;
    w.d = '0;
    for (int i = 0; i < 16; i++) w.d = {w.d[14:0], (i < n) ? mq.pop_front() : 1'b1};
    w.b = 5'(n);
    w.l = lst;
    return w;
  endfunction

  function automatic void model_accept(logic [7:0] d, logic [5:0] l, logic lst);
    int len = (int'(l) > 8) ? 8 : int'(l);
    for (int i = len - 1; i >= 0; i--) mq.push_back(d[i]);
    while (mq.size() > 16 || (mq.size() == 16 && !lst)) exp_q.push_back(pop_word(16, 1'b0));
    if (lst) exp_q.push_back(pop_word(mq.size(), 1'b1));
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    got.delete();
    exp_q.delete();
    mq.delete();
  endtask

  task automatic send(input logic [7:0] d, input logic [5:0] l, input logic lst);
    bit ok = 0;
    in_data  = d;
    in_len   = l;
    in_last  = lst;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for data %0h len %0d", d, l);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  vec_t vecs[14];

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_len    = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    vecs[0]  = '{8'h05, 6'd3,  1'b0, 0, 16'h0,    5'd0,  1'b0, 16'h0,    5'd0, 1'b0};
    vecs[1]  = '{8'hFF, 6'd8,  1'b0, 0, 16'h0,    5'd0,  1'b0, 16'h0,    5'd0, 1'b0};
    vecs[2]  = '{8'h1F, 6'd5,  1'b0, 1, 16'hBFFF, 5'd16, 1'b0, 16'h0,    5'd0, 1'b0};
    vecs[3]  = '{8'h01, 6'd2,  1'b1, 1, 16'h7FFF, 5'd2,  1'b1, 16'h0,    5'd0, 1'b0};
    vecs[4]  = '{8'hFF, 6'd4,  1'b0, 0, 16'h0,    5'd0,  1'b0, 16'h0,    5'd0, 1'b0};
    vecs[5]  = '{8'hFF, 6'd4,  1'b0, 0, 16'h0,    5'd0,  1'b0, 16'h0,    5'd0, 1'b0};
    vecs[6]  = '{8'hFF, 6'd4,  1'b0, 0, 16'h0,    5'd0,  1'b0, 16'h0,    5'd0, 1'b0};
    vecs[7]  = '{8'h00, 6'd9,  1'b1, 2, 16'hFFF0, 5'd16, 1'b0, 16'h0FFF, 5'd4, 1'b1};
    vecs[8]  = '{8'hA7, 6'd0,  1'b0, 0, 16'h0,    5'd0,  1'b0, 16'h0,    5'd0, 1'b0};
    vecs[9]  = '{8'h00, 6'd0,  1'b1, 1, 16'hFFFF, 5'd0,  1'b1, 16'h0,    5'd0, 1'b0};
    vecs[10] = '{8'hAA, 6'd8,  1'b0, 0, 16'h0,    5'd0,  1'b0, 16'h0,    5'd0, 1'b0};
    vecs[11] = '{8'h55, 6'd8,  1'b1, 1, 16'hAA55, 5'd16, 1'b1, 16'h0,    5'd0, 1'b0};
    vecs[12] = '{8'h3C, 6'd63, 1'b0, 0, 16'h0,    5'd0,  1'b0, 16'h0,    5'd0, 1'b0};
    vecs[13] = '{8'hFF, 6'd1,  1'b1, 1, 16'h3CFF, 5'd9,  1'b1, 16'h0,    5'd0, 1'b0};

    do_reset();
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_bits", out_bits, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Table-driven directed vectors with out_ready held high.
    for (int v = 0; v < 14; v++) begin
      got.delete();
      send(vecs[v].d, vecs[v].len, vecs[v].lst);
      cycles(6);
      chk($sformatf("vec%0d_count", v), got.size(), vecs[v].n);
      if (got.size() > 0 && vecs[v].n > 0)
        chk($sformatf("vec%0d_word0", v), {got[0].d, got[0].b, got[0].l},
            {vecs[v].wd0, vecs[v].wb0, vecs[v].wl0});
      if (got.size() > 1 && vecs[v].n > 1)
        chk($sformatf("vec%0d_word1", v), {got[1].d, got[1].b, got[1].l},
            {vecs[v].wd1, vecs[v].wb1, vecs[v].wl1});
    end

    // Latency of a completed word and in_ready across the final-word wait.
    do_reset();
    send(8'h05, 6'd3, 1'b0);
    send(8'hFF, 6'd8, 1'b0);
    in_data = 8'h1F; in_len = 6'd5; in_last = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    chk("lat_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_valid_n1", out_valid, 0);
    @(negedge clk);
    chk("lat_valid_n2", out_valid, 1);
    chk("lat_data", out_data, 16'hBFFF);
    @(posedge clk); #1;
    in_data = 8'h01; in_len = 6'd2; in_last = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("fin_accept_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("fin_flush_ready", in_ready, 0);
    @(negedge clk);
    chk("fin_wait_ready", in_ready, 0);
    chk("fin_word", {out_valid, out_data, out_bits, out_last}, {1'b1, 16'h7FFF, 5'd2, 1'b1});
    @(negedge clk);
    chk("fin_ready_back", in_ready, 1);
    @(posedge clk); #1;

    // Backpressure: output held off, no bits lost.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'hAB, 6'd8, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_held", {out_valid, out_data}, {1'b1, 16'hABAB});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    cycles(8);
    chk("bp_count", got.size(), 2);
    for (int i = 0; i < got.size() && i < 2; i++)
      chk($sformatf("bp_word%0d", i), {got[i].d, got[i].b, got[i].l}, {16'hABAB, 5'd16, 1'b0});

    // Reset mid-stream with buffered bits and a pending word.
    do_reset();
    out_ready = 1'b0;
    send(8'hAB, 6'd8, 1'b0);
    send(8'hAB, 6'd8, 1'b0);
    send(8'hFF, 6'd8, 1'b0);
    send(8'h03, 6'd2, 1'b0);
    @(negedge clk);
    chk("mid_pending", out_valid, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_out_valid", out_valid, 0);
    chk("mid_in_ready", in_ready, 1);
    @(posedge clk); #1;
    got.delete();
    out_ready = 1'b1;
    send(8'hF0, 6'd8, 1'b0);
    send(8'h0F, 6'd8, 1'b0);
    cycles(6);
    chk("mid_count", got.size(), 1);
    if (got.size() > 0) chk("mid_word", {got[0].d, got[0].b, got[0].l}, {16'hF00F, 5'd16, 1'b0});

    // Randomized streams against the bit-queue model with random backpressure.
    do_reset();
    begin
      int n_sent = 0;
      int ncw = 400;
      for (int cyc = 0; cyc < 20000 && n_sent < ncw; cyc++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if (!in_valid) begin
          in_data  = 8'($urandom);
          in_len   = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(9, 63)) : 6'($urandom_range(0, 8));
          in_last  = (n_sent == ncw - 1) || ($urandom_range(0, 7) == 0);
          in_valid = 1'b1;
        end
        @(negedge clk);
        if (in_valid && in_ready) begin
          model_accept(in_data, in_len, in_last);
          n_sent++;
          @(posedge clk); #1;
          in_valid = 1'b0;
        end else begin
          @(posedge clk); #1;
        end
      end
      chk("rnd_all_sent", n_sent, ncw);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 200 && got.size() < exp_q.size(); i++) cycles(1);
      cycles(4);
      chk("rnd_count", got.size(), exp_q.size());
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
        chk($sformatf("rnd_word%0d", i), {got[i].d, got[i].b, got[i].l},
            {exp_q[i].d, exp_q[i].b, exp_q[i].l});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
